// File: rtl/host_pkt2gmii_tx.sv
// Host TX framer: packet-buffer byte stream in, preamble/SFD/frame/pad out on the
// GMII-style bus, with underrun signalling and inter-frame gap. Optional stats: HOST_PKT2GMII_STAT_EN.
module host_pkt2gmii_tx #(
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_FRAME    = 60,
    parameter int IFG_CYCLES   = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] pkt_data,
    input  logic       pkt_valid,
    output logic       pkt_ready,
    output logic       ppt2gtc_gmii_dv,
    output logic       ppt2gtc_gmii_er,
    output logic [7:0] ppt2gtc_gmii_data
`ifdef HOST_PKT2GMII_STAT_EN
    ,
    output logic [31:0] tx_frame_cnt,
    output logic [15:0] tx_underrun_cnt
`endif
);

    localparam int GW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [3:0]    PRE_LAST = 4'(PREAMBLE_LEN - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(IFG_CYCLES - 1);
    localparam logic [10:0]   MIN_B    = 11'(MIN_FRAME);

    typedef enum logic [2:0] {IDLE_S, PRE_S, SFD_S, DATA_S, PAD_S, DROP_S, IFG_S} state_t;

    state_t      state_q, state_d;
    logic [3:0]  pre_q, pre_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [10:0] cnt_q, cnt_d, cnt_inc;
    logic        dv_q, dv_d, er_q, er_d, rdy_q, rdy_d;
    logic [7:0]  data_q, data_d;

    // Byte counter saturates so oversize frames never re-trigger padding.
    assign cnt_inc = (cnt_q == 11'h7ff) ? cnt_q : cnt_q + 11'd1;

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        gap_d   = gap_q;
        cnt_d   = cnt_q;
        dv_d    = 1'b0;
        er_d    = 1'b0;
        data_d  = 8'h00;
        case (state_q)
            IDLE_S: begin
                if (pkt_valid) begin
                    state_d = PRE_S;
                    pre_d   = 4'd0;
                end
            end
            PRE_S: begin
                dv_d   = 1'b1;
                data_d = 8'h55;
                if (pre_q == PRE_LAST) state_d = SFD_S;
                else                   pre_d   = pre_q + 4'd1;
            end
            SFD_S: begin
                dv_d    = 1'b1;
                data_d  = 8'hd5;
                cnt_d   = 11'd0;
                state_d = DATA_S;
            end
            DATA_S: begin
                dv_d = 1'b1;
                if (pkt_valid) begin
                    data_d = pkt_data[7:0];
                    cnt_d  = cnt_inc;
                    if (pkt_data[8]) begin
                        state_d = (cnt_inc < MIN_B) ? PAD_S : IFG_S;
                        gap_d   = '0;
                    end
                end else begin
                    er_d    = 1'b1;
                    state_d = DROP_S;
                end
            end
            PAD_S: begin
                dv_d  = 1'b1;
                cnt_d = cnt_inc;
                if (cnt_inc == MIN_B) begin
                    state_d = IFG_S;
                    gap_d   = '0;
                end
            end
            DROP_S: begin
                if (pkt_valid && pkt_data[8]) begin
                    state_d = IFG_S;
                    gap_d   = '0;
                end
            end
            IFG_S: begin
                if (gap_q == GAP_LAST) state_d = IDLE_S;
                else                   gap_d   = gap_q + 1'b1;
            end
            default: state_d = IDLE_S;
        endcase
        rdy_d = (state_d == DATA_S) || (state_d == DROP_S);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE_S;
            pre_q   <= '0;
            gap_q   <= '0;
            cnt_q   <= '0;
            dv_q    <= 1'b0;
            er_q    <= 1'b0;
            data_q  <= 8'h00;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            gap_q   <= gap_d;
            cnt_q   <= cnt_d;
            dv_q    <= dv_d;
            er_q    <= er_d;
            data_q  <= data_d;
            rdy_q   <= rdy_d;
        end
    end

    assign pkt_ready         = rdy_q;
    assign ppt2gtc_gmii_dv   = dv_q;
    assign ppt2gtc_gmii_er   = er_q;
    assign ppt2gtc_gmii_data = data_q;

`ifdef HOST_PKT2GMII_STAT_EN
    logic [31:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] under_cnt_q, under_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        under_cnt_d = under_cnt_q;
        if ((state_q == DATA_S || state_q == PAD_S) && state_d == IFG_S)
            frame_cnt_d = frame_cnt_q + 32'd1;
        if (er_d) under_cnt_d = under_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
            under_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            under_cnt_q <= under_cnt_d;
        end
    end

    assign tx_frame_cnt    = frame_cnt_q;
    assign tx_underrun_cnt = under_cnt_q;
`endif

endmodule

// File: tb/tb_host_pkt2gmii_tx.sv
// Randomized scoreboard bench for host_pkt2gmii_tx: expected GMII bytes and dv-burst
// lengths are queued at issue time and checked by an independent monitor.
module tb_host_pkt2gmii_tx;
    localparam int PRE = 7;
    localparam int MIN = 60;
    localparam int IFG = 12;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [8:0] pkt_data = '0;
    logic       pkt_valid = 1'b0;
    logic       pkt_ready, dv, er;
    logic [7:0] data;
`ifdef HOST_PKT2GMII_STAT_EN
    logic [31:0] tx_frame_cnt;
    logic [15:0] tx_underrun_cnt;
`endif

    host_pkt2gmii_tx #(.PREAMBLE_LEN(PRE), .MIN_FRAME(MIN), .IFG_CYCLES(IFG)) dut (
        .clk(clk), .rst(rst), .pkt_data(pkt_data), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
        .ppt2gtc_gmii_dv(dv), .ppt2gtc_gmii_er(er), .ppt2gtc_gmii_data(data)
`ifdef HOST_PKT2GMII_STAT_EN
        , .tx_frame_cnt(tx_frame_cnt), .tx_underrun_cnt(tx_underrun_cnt)
`endif
    );

    always #4 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [8:0] exp_q[$];
    int len_q[$];
    logic [7:0] fb[0:2199];
    int exp_frames = 0;
    int exp_under = 0;
    int run = 0;
    int low = 0;
    int last_gap = 0;
    bit seen = 0;

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Reference: what a frame of n bytes should look like on the wire.
    // uk >= 0 means the stream stalls when byte uk is due.
    task automatic model(input int n, input int uk);
        for (int i = 0; i < PRE; i++) exp_q.push_back({1'b0, 8'h55});
        exp_q.push_back({1'b0, 8'hd5});
        if (uk >= 0) begin
            for (int i = 0; i < uk; i++) exp_q.push_back({1'b0, fb[i]});
            exp_q.push_back({1'b1, 8'h00});
            len_q.push_back(PRE + 1 + uk + 1);
            exp_under++;
        end else begin
            for (int i = 0; i < n; i++) exp_q.push_back({1'b0, fb[i]});
            for (int i = n; i < MIN; i++) exp_q.push_back({1'b0, 8'h00});
            len_q.push_back(PRE + 1 + ((n > MIN) ? n : MIN));
            exp_frames++;
        end
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) fb[i] = 8'($urandom);
    endtask

    task automatic send(input int n, input int uk, input bit eop);
        int i = 0;
        int waited = 0;
        bit stalled = 0;
        while (i < n) begin
            @(negedge clk);
            if (i == uk && !stalled && pkt_ready) begin
                pkt_valid = 1'b0;
                stalled = 1;
            end else begin
                pkt_valid = 1'b1;
                pkt_data = {eop && (i == n - 1), fb[i]};
                if (pkt_ready) begin
                    i++;
                    waited = 0;
                end else waited++;
            end
            if (waited > 200) begin
                total++;
                bad++;
                $display("FAIL ready_timeout: byte %0d never accepted", i);
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        pkt_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic frame(input int n, input int uk);
        fill(n);
        model(n, uk);
        send(n, uk, 1'b1);
    endtask

    // Monitor: every dv cycle consumes one expected byte; each dv burst one length.
    always @(negedge clk) begin
        logic [8:0] e;
        if (dv) begin
            if (run == 0) begin
                if (seen) begin
                    total++;
                    if (low < IFG + 1) begin
                        bad++;
                        $display("FAIL ifg_gap: got %0d cycles expected >= %0d", low, IFG + 1);
                    end
                end
                last_gap = low;
                seen = 1;
            end
            low = 0;
            run++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_dv: er=%0b data=%02h with nothing expected", er, data);
            end else begin
                e = exp_q.pop_front();
                if ({er, data} !== e) begin
                    bad++;
                    $display("FAIL gmii_byte: got er=%0b data=%02h expected er=%0b data=%02h",
                             er, data, e[8], e[7:0]);
                end
            end
        end else begin
            low++;
            if (run > 0) begin
                total++;
                if (len_q.size() == 0) begin
                    bad++;
                    $display("FAIL dv_len: burst of %0d with none expected", run);
                end else begin
                    int l;
                    l = len_q.pop_front();
                    if (l != run) begin
                        bad++;
                        $display("FAIL dv_len: got %0d expected %0d", run, l);
                    end
                end
                run = 0;
            end
        end
    end

    initial begin
        #5;
        check("reset_dv", dv, 0);
        check("reset_er", er, 0);
        check("reset_data", data, 0);
        check("reset_ready", pkt_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        frame(64, -1); idle(20);
        frame(10, -1); idle(20);

        // back-to-back: valid held continuously
        frame(60, -1);
        frame(60, -1);
        idle(5);
        check("b2b_gap", last_gap, IFG + 1);
        idle(80);

        frame(100, 20); idle(20);
        frame(40, 0); idle(20);
        frame(2050, -1); idle(20);
        frame(59, -1); idle(20);
        frame(61, -1); idle(20);

        // reset during byte 30
        fill(100);
        for (int i = 0; i < PRE; i++) exp_q.push_back({1'b0, 8'h55});
        exp_q.push_back({1'b0, 8'hd5});
        for (int i = 0; i < 30; i++) exp_q.push_back({1'b0, fb[i]});
        len_q.push_back(PRE + 1 + 30);
        send(30, -1, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_dv", dv, 0);
        check("rst_er", er, 0);
        check("rst_data", data, 0);
        check("rst_ready", pkt_ready, 0);
        pkt_valid = 1'b0;
        exp_frames = 0;
        exp_under = 0;
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        for (int k = 0; k < 14; k++) begin
            int n, uk;
            n = $urandom_range(1, 130);
            uk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
            frame(n, uk);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 30));
        end
        idle(200);

        check("exp_bytes_left", exp_q.size(), 0);
        check("exp_bursts_left", len_q.size(), 0);
`ifdef HOST_PKT2GMII_STAT_EN
        check("stat_frames", tx_frame_cnt, exp_frames);
        check("stat_underruns", tx_underrun_cnt, exp_under);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: simulation did not complete");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "timeout");
    end
endmodule
